// File: rtl/jogo_memoria_rodadas.sv
// Round-based memory game: datapath counters plus control FSM, one jogada added per rodada.
// Optional per-jogada timeout is enabled by defining JOGO_TIMEOUT_EN.
module jogo_memoria_rodadas #(
    parameter int N_CHAVES       = 4,
    parameter int N_JOGADAS      = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic [N_CHAVES-1:0] mem_dado,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                acertou,
    output logic                errou,
    output logic                pronto,
    output logic [N_CHAVES-1:0] leds,
    output logic [3:0]          db_estado,
    output logic [ADDR_W-1:0]   db_rodada,
    output logic [ADDR_W-1:0]   db_contagem,
    output logic                db_igual,
    output logic                db_tem_jogada,
    output logic                db_timeout
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_JOGADA  = 4'h2,
        REGISTRA       = 4'h3,
        COMPARA        = 4'h4,
        PROXIMA_JOGADA = 4'h5,
        PROXIMA_RODADA = 4'h6,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    generate
        if (N_JOGADAS < 2 || (2 ** ADDR_W) < N_JOGADAS || TIMEOUT_CICLOS < 2) begin : g_param_invalido
            $error("jogo_memoria_rodadas: invalid parameter combination");
        end
    endgenerate

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   contagem_q, contagem_d;
    logic [ADDR_W-1:0]   rodada_q, rodada_d;
    logic [N_CHAVES-1:0] jogada_q, jogada_d;
    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic                chaves_prev_q, chaves_prev_d;

    logic tem_jogada;
    logic jogada_feita;
    logic igual;
    logic fim_rodada;
    logic ultima_rodada;
    logic tempo_esgotado;

    assign tem_jogada    = |chaves;
    assign jogada_feita  = tem_jogada & ~chaves_prev_q;
    assign igual         = (jogada_q == mem_dado);
    assign fim_rodada    = (contagem_q == rodada_q);
    assign ultima_rodada = (rodada_q == ADDR_W'(N_JOGADAS - 1));

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);

    logic [TW-1:0] espera_cont_q, espera_cont_d;

    // Counter is zero whenever espera_jogada is (re)entered, since it clears in every other state.
    always_comb begin
        espera_cont_d = '0;
        if (estado_q == ESPERA_JOGADA) begin
            espera_cont_d = espera_cont_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            espera_cont_q <= '0;
        end else begin
            espera_cont_q <= espera_cont_d;
        end
    end

    assign tempo_esgotado = (estado_q == ESPERA_JOGADA) && (espera_cont_q == TW'(TIMEOUT_CICLOS - 1));
    assign db_timeout     = (estado_q == FIM_TIMEOUT);
`else
    assign tempo_esgotado = 1'b0;
    assign db_timeout     = 1'b0;
`endif

    always_comb begin
        estado_d      = estado_q;
        contagem_d    = contagem_q;
        rodada_d      = rodada_q;
        jogada_d      = jogada_q;
        leds_d        = leds_q;
        chaves_prev_d = tem_jogada;

        unique case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                contagem_d = '0;
                rodada_d   = '0;
                leds_d     = '0;
                estado_d   = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A press on the terminal timeout cycle still counts as a jogada.
                if (jogada_feita)        estado_d = REGISTRA;
                else if (tempo_esgotado) estado_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                jogada_d = chaves;
                leds_d   = chaves;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (!igual)                         estado_d = FIM_ERRO;
                else if (fim_rodada && ultima_rodada) estado_d = FIM_ACERTO;
                else if (fim_rodada)                estado_d = PROXIMA_RODADA;
                else                                estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: begin
                contagem_d = contagem_q + ADDR_W'(1);
                estado_d   = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                rodada_d   = rodada_q + ADDR_W'(1);
                contagem_d = '0;
                estado_d   = ESPERA_JOGADA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= INICIAL;
            contagem_q    <= '0;
            rodada_q      <= '0;
            jogada_q      <= '0;
            leds_q        <= '0;
            chaves_prev_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            contagem_q    <= contagem_d;
            rodada_q      <= rodada_d;
            jogada_q      <= jogada_d;
            leds_q        <= leds_d;
            chaves_prev_q <= chaves_prev_d;
        end
    end

    assign mem_addr      = contagem_q;
    assign acertou       = (estado_q == FIM_ACERTO);
    assign errou         = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    assign pronto        = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    assign leds          = leds_q;
    assign db_estado     = estado_q;
    assign db_rodada     = rodada_q;
    assign db_contagem   = contagem_q;
    assign db_igual      = igual;
    assign db_tem_jogada = tem_jogada;

endmodule

// File: doc/jogo_memoria_rodadas.md
Name: jogo_memoria_rodadas

Overview:
Parametrised round-based successor of the exp5 game datapath and FSM for the memory game. The sequence grows one jogada per rodada: rodada r requires the player to repeat jogadas 0..r. Player moves come in on `chaves`; expected moves are read from an external sequence memory through a combinational-read address/data pair. The block sits under the top-level circuito, with hex-display decoding done outside.

Parameters:
- N_CHAVES, 4: width of a jogada (one-hot, one bit per LED/switch).
- N_JOGADAS, 16: sequence length; also the number of rodadas; must be ≥2.
- ADDR_W, 4: address/counter width; must satisfy 2**ADDR_W ≥ N_JOGADAS.
- TIMEOUT_CICLOS, 5000: clock cycles allowed per jogada; used only with the optional feature.

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- iniciar, in, 1: start/restart request.
- chaves, in, N_CHAVES: player switches.
- mem_dado, in, N_CHAVES: expected jogada at mem_addr, combinational read.
- mem_addr, out, ADDR_W: equals the jogada counter (db_contagem).
- acertou, out, 1: whole sequence completed correctly.
- errou, out, 1: wrong jogada, or timeout.
- pronto, out, 1: game ended.
- leds, out, N_CHAVES: last registered jogada.
- db_estado, out, 4: FSM state code.
- db_rodada, out, ADDR_W: current rodada.
- db_contagem, out, ADDR_W: jogada index within the rodada.
- db_igual, out, 1: registered jogada == mem_dado.
- db_tem_jogada, out, 1: |chaves.
- db_timeout, out, 1: game ended by timeout.

Behaviour:
- Reset (synchronous, active-high): applies at the next rising edge, including mid-game.
  - FSM goes to inicial.
  - contagem, rodada, jogada register and chaves_prev are cleared.
  - acertou, errou, pronto, leds, db_timeout all = 0.
- Jogada detection:
  - chaves_prev <= |chaves every cycle.
  - jogada_feita = (|chaves) & ~chaves_prev, so it pulses exactly once per press.
  - Holding chaves produces one jogada. Chaves must return to 0 before the next jogada counts.
  - Multi-bit chaves values are accepted and compared as-is; they mismatch any one-hot mem_dado.
- FSM states (db_estado code):
  - inicial (0): waits for iniciar=1, then goes to preparacao. Outputs are 0.
  - preparacao (1): one cycle. Clears contagem, rodada and leds, then goes to espera_jogada.
  - espera_jogada (2): holds until jogada_feita, then goes to registra.
  - registra (3): latches the jogada register <= chaves and sets leds <= chaves. Goes to compara.
  - compara (4): igual = (jogada == mem_dado) at mem_addr = contagem.
    - If not igual: go to fim_erro.
    - Else if contagem == rodada and rodada == N_JOGADAS-1: go to fim_acerto.
    - Else if contagem == rodada: go to proxima_rodada.
    - Else: go to proxima_jogada.
  - proxima_jogada (5): contagem++, then go to espera_jogada.
  - proxima_rodada (6): rodada++, contagem <= 0, then go to espera_jogada.
  - fim_acerto (A): pronto=1, acertou=1.
  - fim_erro (E): pronto=1, errou=1.
  - In fim_acerto and fim_erro, outputs and counters are held. iniciar=1 goes to preparacao; otherwise the state is held.
- Latency: with chaves first non-zero in cycle t (in espera_jogada), the FSM is in compara at t+2. The end-state outputs are visible from t+3.
- Ignored events:
  - iniciar outside inicial and the fim states is ignored.
  - A jogada_feita in any state other than espera_jogada is lost. The bench must wait ≥4 cycles between presses.
- Width rules: counters never exceed N_JOGADAS-1 and have no wrap-around. db_igual is combinational from the jogada register and mem_dado.

Optional Feature:
- Macro: JOGO_TIMEOUT_EN.
- When defined:
  - An internal counter is cleared on every entry into espera_jogada and increments while in espera_jogada.
  - When it reaches TIMEOUT_CICLOS-1 with no jogada_feita in that same cycle, the FSM goes to fim_timeout (code D).
  - fim_timeout asserts pronto=1, errou=1, db_timeout=1, and leaves it like the other fim states.
  - If jogada_feita and terminal count occur in the same cycle, the jogada wins.
- When undefined: no timeout counter exists, state D is unreachable, and db_timeout is tied to 0.

Test Plan:
- Reset, then 10 idle cycles -> db_estado=0; acertou=errou=pronto=0; leds=0000.
- N_JOGADAS=4, memory 0001,0010,0100,1000; iniciar pulse; all 10 correct jogadas (rodadas 0..3) -> acertou=1, pronto=1, db_rodada=3, db_estado=A, 3 cycles after the last press.
- Same memory; rodada 1 sequence 0001 then 0100 -> errou=1, pronto=1, db_rodada=1, db_contagem=1, leds=0100, db_estado=E.
- In rodada 0, hold 0001 for 20 cycles, then release -> exactly one jogada registered; the FSM is in espera_jogada with db_rodada=1 and db_contagem=0.
- From fim_acerto, iniciar=1 for 5 cycles -> db_estado=1 then 2, acertou/pronto cleared, db_rodada=0. reset=1 mid-rodada 2 -> db_estado=0 on the next edge, all outputs 0.
- JOGO_TIMEOUT_EN defined, TIMEOUT_CICLOS=100: iniciar, then no input for 100 cycles -> errou=1, pronto=1, db_timeout=1, db_estado=D. A press at cycle 99 -> normal compara instead.
